// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locked arbiter sharing one byte-wide UART TX engine among NUM_REQ sources.
// Optional stall timeout is compiled in with `define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ        = 3,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   tx_valid,
    output logic [7:0]             tx_data,
    input  logic                   tx_ready,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy,
    output logic                   timeout
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = 17;

    typedef enum logic {
        S_IDLE,
        S_XFER
    } state_e;

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]     owner_q, owner_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;

    logic [7:0]           src_byte [NUM_REQ];
    logic                 own_valid;
    logic                 own_last;
    logic                 xfer_fire;
    logic                 any_req;
    logic [PTR_W-1:0]     pick_idx;
    int unsigned          cand;
    logic                 stall_hit;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_bytes
        assign src_byte[i] = req_data[8*i +: 8];
    end

    // Datapath is steered combinationally by the registered owner.
    always_comb begin
        busy      = (state_q == S_XFER);
        grant     = grant_q;
        own_valid = req_valid[owner_q];
        own_last  = req_last[owner_q];
        tx_valid  = busy && own_valid;
        tx_data   = busy ? src_byte[owner_q] : 8'h00;
        req_ready = '0;
        if (busy) begin
            req_ready[owner_q] = tx_ready;
        end
        xfer_fire = tx_valid && tx_ready;
    end

    // First requester after rr_ptr, wrapping; highest-priority candidate is applied last.
    always_comb begin
        any_req  = |req_valid;
        pick_idx = '0;
        cand     = 0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = (32'(rr_ptr_q) + 32'(i)) % NUM_REQ;
            if (req_valid[PTR_W'(cand)]) begin
                pick_idx = PTR_W'(cand);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    owner_d           = pick_idx;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    state_d           = S_XFER;
                end
            end
            S_XFER: begin
                if ((xfer_fire && own_last) || stall_hit) begin
                    rr_ptr_d = owner_q;
                    grant_d  = '0;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            grant_q  <= '0;
            owner_q  <= '0;
            rr_ptr_q <= PTR_W'(NUM_REQ - 1);
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             timeout_q;

    assign stall_hit = busy && !own_valid && (stall_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign timeout   = timeout_q;

    // Only source-side silence counts; a TX-side stall with valid data holds the count.
    always_comb begin
        stall_d = stall_q;
        if (!busy || xfer_fire) begin
            stall_d = '0;
        end else if (!own_valid) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            stall_q   <= stall_d;
            timeout_q <= stall_hit;
        end
    end
`else
    logic unused_cfg;

    assign stall_hit  = 1'b0;
    assign timeout    = 1'b0;
    assign unused_cfg = ^{32'(TIMEOUT_CYCLES), 32'(CNT_W)};
`endif

endmodule
